// File: rtl/program_counter_stack_pkg.sv
// Shared defaults and command decode for the SAP-family program counter with return stack.
package program_counter_stack_pkg;

  localparam int unsigned AW_DEFAULT    = 4;
  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned SPW_DEFAULT   = 3;

  // One command wins per falling edge; the rest of the control word is ignored.
  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_LOAD,
    CMD_RET,
    CMD_CALL
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic call, input logic ret,
                                      input logic lp, input logic cp);
    if (call)      return CMD_CALL;
    else if (ret)  return CMD_RET;
    else if (lp)   return CMD_LOAD;
    else if (cp)   return CMD_INC;
    else           return CMD_HOLD;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses. The parent only issues legal push/pop, so no
// bounds protection is done here.
module pc_return_stack
  import program_counter_stack_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int SPW   = SPW_DEFAULT
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  push_data,
  output logic [AW-1:0]  top_data,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] entries [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_idx   = IW'(sp);
  assign rd_idx   = IW'(sp - SPW'(1));
  assign top_data = entries[rd_idx];
  assign full     = (sp == SPW'(DEPTH));
  assign empty    = (sp == '0);

  // Entry array and stack pointer update on the falling edge, cleared asynchronously.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (push) begin
      entries[wr_idx] <= push_data;
      sp              <= sp + SPW'(1);
    end else if (pop) begin
      sp <= sp - SPW'(1);
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with jump, call/return through a return stack, sticky stack
// error flags and a wrap pulse. State changes mid-cycle on the falling edge.
module program_counter_stack
  import program_counter_stack_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int SPW   = SPW_DEFAULT
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           Cp,
  input  logic           Ep,
  input  logic           Lp,
  input  logic           Call,
  input  logic           Ret,
  input  logic [AW-1:0]  from_WBUS,
  output wire  [AW-1:0]  to_WBUS,
  output logic [AW-1:0]  pc_out,
  output logic [SPW-1:0] sp,
  output logic           stk_full,
  output logic           stk_empty,
  output logic           stk_ovf,
  output logic           stk_unf,
  output logic           pc_wrap
);

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] top_data;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          unf_set;
  logic          wrap_next;
  cmd_e          cmd;

  assign cmd     = decode_cmd(Call, Ret, Lp, Cp);
  assign pc_out  = pc;
  assign to_WBUS = Ep ? pc : {AW{1'bz}};

  pc_return_stack #(.AW(AW), .DEPTH(DEPTH), .SPW(SPW)) u_stack (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .push_data (pc + AW'(1)),
    .top_data  (top_data),
    .sp        (sp),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Resolve the winning command into next PC, stack strobes and flag sets.
  always_comb begin
    pc_next   = pc;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    wrap_next = 1'b0;
    case (cmd)
      CMD_CALL: begin
        if (stk_full) begin
          ovf_set = 1'b1;
        end else begin
          push    = 1'b1;
          pc_next = from_WBUS;
        end
      end
      CMD_RET: begin
        if (stk_empty) begin
          unf_set = 1'b1;
        end else begin
          pop     = 1'b1;
          pc_next = top_data;
        end
      end
      CMD_LOAD: pc_next = from_WBUS;
      CMD_INC: begin
        pc_next   = pc + AW'(1);
        wrap_next = (pc == '1);
      end
      default: pc_next = pc;
    endcase
  end

  // PC, sticky error flags and the single-cycle wrap pulse.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      pc      <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      pc_wrap <= 1'b0;
    end else begin
      pc      <= pc_next;
      stk_ovf <= stk_ovf | ovf_set;
      stk_unf <= stk_unf | unf_set;
      pc_wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench: the driver pushes model expectations per falling edge,
// an independent monitor pops and compares just after each falling edge.
module tb_program_counter_stack;

  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int SPW   = 3;
  localparam int M     = 1 << AW;

  logic           clk = 1'b0;
  logic           clr = 1'b0;
  logic           Cp = 1'b0, Ep = 1'b0, Lp = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic [AW-1:0]  from_WBUS = '0;
  wire  [AW-1:0]  to_WBUS;
  logic [AW-1:0]  pc_out;
  logic [SPW-1:0] sp;
  logic           stk_full, stk_empty, stk_ovf, stk_unf, pc_wrap;
  logic [AW-1:0]  zv = 'z;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int pc;
    int sp;
    bit full;
    bit empty;
    bit ovf;
    bit unf;
    bit wrap;
    bit ep;
  } exp_t;

  exp_t exp_q[$];

  int m_pc = 0;
  int m_stack[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  program_counter_stack #(.AW(AW), .DEPTH(DEPTH), .SPW(SPW)) dut (
    .clk(clk), .clr(clr), .Cp(Cp), .Ep(Ep), .Lp(Lp), .Call(Call), .Ret(Ret),
    .from_WBUS(from_WBUS), .to_WBUS(to_WBUS), .pc_out(pc_out), .sp(sp),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_ovf(stk_ovf),
    .stk_unf(stk_unf), .pc_wrap(pc_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one control word and record what the next falling edge must produce.
  task automatic step(input bit call, input bit ret, input bit lp, input bit cp,
                      input bit ep, input int bus);
    exp_t e;
    bit   wrap;
    @(posedge clk);
    Call = call; Ret = ret; Lp = lp; Cp = cp; Ep = ep;
    from_WBUS = AW'(bus);
    wrap = 0;
    if (call) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back((m_pc + 1) % M);
        m_pc = bus % M;
      end else m_ovf = 1;
    end else if (ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else m_unf = 1;
    end else if (lp) begin
      m_pc = bus % M;
    end else if (cp) begin
      wrap = (m_pc == M - 1);
      m_pc = (m_pc + 1) % M;
    end
    e.pc = m_pc; e.sp = m_stack.size();
    e.full = (e.sp == DEPTH); e.empty = (e.sp == 0);
    e.ovf = m_ovf; e.unf = m_unf; e.wrap = wrap; e.ep = ep;
    exp_q.push_back(e);
  endtask

  // Clear between edges and check the cleared outputs before the next edge.
  task automatic do_reset();
    @(posedge clk);
    Call = 0; Ret = 0; Lp = 0; Cp = 0; Ep = 1;
    #2 clr = 1;
    #1;
    chk("rst_pc", pc_out, 0);
    chk("rst_bus", to_WBUS, 0);
    chk("rst_sp", sp, 0);
    chk("rst_empty", stk_empty, 1);
    chk("rst_full", stk_full, 0);
    chk("rst_ovf", stk_ovf, 0);
    chk("rst_unf", stk_unf, 0);
    chk("rst_wrap", pc_wrap, 0);
    #1 clr = 0;
    Ep = 0;
    m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  // Monitor: compare every falling-edge result against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc_out, e.pc);
        chk("sp", sp, e.sp);
        chk("full", stk_full, e.full);
        chk("empty", stk_empty, e.empty);
        chk("ovf", stk_ovf, e.ovf);
        chk("unf", stk_unf, e.unf);
        chk("wrap", pc_wrap, e.wrap);
        if (e.ep) chk("bus_drive", to_WBUS, e.pc);
        else      chk("bus_release", to_WBUS, zv);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, i[0], 0);
    settle();
    chk("count_end", pc_out, 1);

    do_reset();
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 1, 'hA);
    settle();
    chk("jump", pc_out, 'hA);
    step(0, 0, 0, 1, 0, 0);
    settle();
    chk("jump_inc", pc_out, 'hB);

    do_reset();
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 8);
    step(1, 0, 0, 1, 0, 'hC);
    step(0, 1, 0, 0, 1, 0);
    settle();
    chk("nest_ret1", pc_out, 9);
    step(0, 1, 0, 0, 0, 0);
    settle();
    chk("nest_ret2", pc_out, 3);
    chk("nest_empty", stk_empty, 1);

    do_reset();
    for (int t = 4; t <= 7; t++) step(1, 0, 0, 0, 0, t);
    settle();
    chk("ovf_full", stk_full, 1);
    step(1, 0, 0, 1, 0, 'hE);
    settle();
    chk("ovf_pc", pc_out, 7);
    chk("ovf_flag", stk_ovf, 1);
    repeat (4) step(0, 1, 0, 0, 0, 0);
    settle();
    chk("ovf_last_ret", pc_out, 1);
    chk("ovf_sticky", stk_ovf, 1);

    do_reset();
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    settle();
    chk("unf_inc", pc_out, 1);
    chk("unf_flag", stk_unf, 1);

    do_reset();
    step(1, 0, 0, 0, 0, 5);
    step(1, 0, 0, 0, 0, 9);
    settle();
    chk("mid_sp", sp, 2);
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    settle();
    chk("mid_unf", stk_unf, 1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 60,
                $urandom_range(0, 1) == 1, int'($urandom_range(0, M - 1)));
    end

    step(0, 0, 0, 0, 0, 0);
    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
